// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: opcodes, PC-select encodings and sequencer states.
// Imported by the PC, the fetch sequencer and its decode helper.
package fetch_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_JMP = 4'hC;
    localparam logic [OPC_W-1:0] OPC_JR  = 4'hD;
    localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_SR1 = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    typedef struct packed {
        logic [1:0] pc_ctl;
        logic       is_halt;
    } decode_t;

    function automatic decode_t decode_opcode(input logic [OPC_W-1:0] opcode);
        decode_t d;
        d.pc_ctl  = PC_INC;
        d.is_halt = 1'b0;
        case (opcode)
            OPC_JMP: d.pc_ctl  = PC_IMM;
            OPC_JR:  d.pc_ctl  = PC_SR1;
            OPC_HLT: d.is_halt = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational opcode decode: selects the PC next-value source and flags halt.
module fetch_decode
    import fetch_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [1:0]       pc_ctl,
    output logic             is_halt
);

    decode_t dec;

    always_comb begin
        dec     = decode_opcode(opcode);
        pc_ctl  = dec.pc_ctl;
        is_halt = dec.is_halt;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: fetches at pc_in, holds the word in the IR, offers it
// to execute, then strobes the PC update. Moore FSM; outputs depend on state/IR only.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_BITS    = 6,
    parameter int INSTR_BITS = 16,
    parameter int OPC_BITS   = OPC_W
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic [PC_BITS-1:0]    pc_in,
    output logic [PC_BITS-1:0]    mem_addr,
    output logic                  mem_req,
    input  logic                  mem_ready,
    input  logic [INSTR_BITS-1:0] mem_data,
    output logic [INSTR_BITS-1:0] ir_out,
    output logic                  ir_valid,
    input  logic                  exec_ready,
    output logic                  pc_latch_data,
    output logic [1:0]            pc_ctl,
    output logic [PC_BITS-1:0]    imm,
    output logic                  halted
);

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [INSTR_BITS-1:0] ir_reg;
    logic [INSTR_BITS-1:0] ir_next;
    logic [OPC_BITS-1:0]   opcode;
    logic [1:0]            dec_pc_ctl;
    logic                  dec_is_halt;

    assign opcode = ir_reg[INSTR_BITS-1 -: OPC_BITS];

    fetch_decode u_decode (
        .opcode  (opcode),
        .pc_ctl  (dec_pc_ctl),
        .is_halt (dec_is_halt)
    );

    // Each handshake input is only looked at in the state that owns it.
    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (mem_ready) begin
                    ir_next    = mem_data;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (exec_ready) begin
                    state_next = dec_is_halt ? ST_HALT : ST_UPDATE;
                end
            end
            ST_UPDATE: state_next = ST_REQ;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
        end
    end

    // Reset clears state_reg asynchronously, so every strobe drops with reset.
    assign mem_addr      = pc_in;
    assign mem_req       = (state_reg == ST_REQ);
    assign ir_valid      = (state_reg == ST_ISSUE);
    assign pc_latch_data = (state_reg == ST_UPDATE);
    assign pc_ctl        = (state_reg == ST_UPDATE) ? dec_pc_ctl : PC_INC;
    assign halted        = (state_reg == ST_HALT);
    assign ir_out        = ir_reg;
    assign imm           = ir_reg[PC_BITS-1:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC model closing the update loop.
module tb_fetch_sequencer;

    logic        clka = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  pc_in;
    logic [5:0]  mem_addr;
    logic        mem_req;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        exec_ready = 1'b0;
    logic        pc_latch_data;
    logic [1:0]  pc_ctl;
    logic [5:0]  imm;
    logic        halted;

    localparam logic [5:0] SR1_VAL = 6'h15;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .clka          (clka),
        .reset         (reset),
        .pc_in         (pc_in),
        .mem_addr      (mem_addr),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .ir_out        (ir_out),
        .ir_valid      (ir_valid),
        .exec_ready    (exec_ready),
        .pc_latch_data (pc_latch_data),
        .pc_ctl        (pc_ctl),
        .imm           (imm),
        .halted        (halted)
    );

    always #5 clka = ~clka;

    // Program counter as the surrounding design would build it.
    always @(posedge clka or posedge reset) begin
        if (reset) begin
            pc_in <= 6'd0;
        end else if (pc_latch_data) begin
            case (pc_ctl)
                2'b00:   pc_in <= pc_in + 6'd1;
                2'b01:   pc_in <= imm;
                2'b10:   pc_in <= SR1_VAL;
                default: pc_in <= pc_in;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".mem_req"}, 16'(mem_req), 16'h0);
        check_eq({tag, ".ir_valid"}, 16'(ir_valid), 16'h0);
        check_eq({tag, ".pc_latch"}, 16'(pc_latch_data), 16'h0);
        check_eq({tag, ".pc_ctl"}, 16'(pc_ctl), 16'h0);
    endtask

    // Assert reset, check reset values, release and land in the first REQ cycle.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_quiet("rst");
        check_eq("rst.halted", 16'(halted), 16'h0);
        check_eq("rst.ir_out", ir_out, 16'h0000);
        check_eq("rst.imm", 16'(imm), 16'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        check_quiet("idle");
        step();
        check_eq("first_req", 16'(mem_req), 16'h1);
        $display("reset released, first REQ at addr %0d", mem_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Back-to-back non-control instructions, PC walks 0..63 and wraps.
        mem_ready  = 1'b1;
        exec_ready = 1'b1;
        mem_data   = 16'h1000;
        do_reset();
        for (int k = 0; k < 66; k++) begin
            check_eq("seq.mem_req", 16'(mem_req), 16'h1);
            check_eq("seq.addr", 16'(mem_addr), 16'(k % 64));
            check_eq("seq.req_latch", 16'(pc_latch_data), 16'h0);
            step();
            check_eq("seq.ir_valid", 16'(ir_valid), 16'h1);
            check_eq("seq.ir_out", ir_out, 16'h1000);
            step();
            check_eq("seq.latch", 16'(pc_latch_data), 16'h1);
            check_eq("seq.pc_ctl", 16'(pc_ctl), 16'h0);
            step();
            if (k % 16 == 0 || k >= 62)
                $display("seq txn %0d addr=%0d ir=%h", k, k % 64, ir_out);
        end

        // Memory stalls for 4 cycles.
        mem_ready = 1'b0;
        exec_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check_eq("stall.mem_req", 16'(mem_req), 16'h1);
            check_eq("stall.ir_valid", 16'(ir_valid), 16'h0);
            step();
        end
        mem_ready = 1'b1;
        mem_data  = 16'h1234;
        check_eq("stall.mem_req_end", 16'(mem_req), 16'h1);
        step();
        mem_ready = 1'b0;
        check_eq("stall.ir_valid_rise", 16'(ir_valid), 16'h1);
        check_eq("stall.ir_out", ir_out, 16'h1234);
        $display("stall txn ir=%h after 4 wait cycles", ir_out);
        step();
        check_eq("stall.latch", 16'(pc_latch_data), 16'h1);
        step();
        check_eq("stall.next_addr", 16'(mem_addr), 16'd1);

        // JMP with execute stalled; memory inputs toggled during ISSUE are ignored.
        mem_ready  = 1'b1;
        mem_data   = 16'hC02A;
        exec_ready = 1'b0;
        step();
        mem_data = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            check_eq("jmp.ir_valid", 16'(ir_valid), 16'h1);
            check_eq("jmp.ir_hold", ir_out, 16'hC02A);
            check_eq("jmp.no_latch", 16'(pc_latch_data), 16'h0);
            step();
        end
        exec_ready = 1'b1;
        mem_ready  = 1'b0;
        check_eq("jmp.issue_end", 16'(ir_valid), 16'h1);
        step();
        check_eq("jmp.latch", 16'(pc_latch_data), 16'h1);
        check_eq("jmp.pc_ctl", 16'(pc_ctl), 16'h1);
        check_eq("jmp.imm", 16'(imm), 16'h2A);
        step();
        check_eq("jmp.mem_req", 16'(mem_req), 16'h1);
        check_eq("jmp.target", 16'(mem_addr), 16'd42);
        $display("jmp txn ir=C02A target=%0d", mem_addr);

        // JR: pc_ctl=10 only in UPDATE.
        mem_ready = 1'b1;
        mem_data  = 16'hD000;
        step();
        check_eq("jr.issue_latch", 16'(pc_latch_data), 16'h0);
        check_eq("jr.issue_ctl", 16'(pc_ctl), 16'h0);
        step();
        check_eq("jr.latch", 16'(pc_latch_data), 16'h1);
        check_eq("jr.pc_ctl", 16'(pc_ctl), 16'h2);
        step();
        check_eq("jr.req_latch", 16'(pc_latch_data), 16'h0);
        check_eq("jr.target", 16'(mem_addr), 16'(SR1_VAL));
        $display("jr txn ir=D000 target=%0d", mem_addr);

        // HLT: sequencer stops for good.
        mem_data = 16'hF000;
        step();
        check_eq("hlt.ir_valid", 16'(ir_valid), 16'h1);
        step();
        for (int k = 0; k < 6; k++) begin
            mem_ready  = k[0];
            exec_ready = ~k[0];
            check_eq("hlt.halted", 16'(halted), 16'h1);
            check_quiet("hlt");
            step();
        end
        $display("hlt txn ir=F000 halted=%0d", halted);

        // Reset in the middle of REQ discards the pending response.
        mem_ready  = 1'b1;
        exec_ready = 1'b1;
        mem_data   = 16'h1000;
        do_reset();
        step();
        step();
        step();
        mem_ready = 1'b0;
        check_eq("mid.pre_req", 16'(mem_req), 16'h1);
        check_eq("mid.pre_ir", ir_out, 16'h1000);
        mem_ready = 1'b1;
        mem_data  = 16'h5678;
        reset     = 1'b1;
        #1;
        check_eq("mid.mem_req", 16'(mem_req), 16'h0);
        check_eq("mid.ir_out", ir_out, 16'h0000);
        step();
        reset = 1'b0;
        #1;
        check_eq("mid.idle_req", 16'(mem_req), 16'h0);
        check_eq("mid.idle_ir", ir_out, 16'h0000);
        step();
        check_eq("mid.req", 16'(mem_req), 16'h1);
        check_eq("mid.req_ir", ir_out, 16'h0000);
        check_eq("mid.addr", 16'(mem_addr), 16'd0);
        step();
        check_eq("mid.capture", ir_out, 16'h5678);
        $display("mid-reset txn ir=%h", ir_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that sits directly downstream of the program counter. Each instruction it presents the PC value to program memory, waits for the read handshake, and latches the returned word into the instruction register. It then hands the instruction to the execute stage and drives the PC's update controls (`pc_latch_data`, `pc_ctl`, `imm`) for the next fetch. Control flow is a single Moore FSM; it handles unconditional jumps, register jumps and halt.

## Interface
- `PC_BITS`, 6, PC/address width; matches the PC.
- `INSTR_BITS`, 16, instruction word width.
- `OPC_BITS`, 4, opcode field width; the opcode is `ir[INSTR_BITS-1 -: OPC_BITS]`.

Ports:
- `clka`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  PC_BITS  current PC (the PC's `pc_out`).
- `mem_addr`  out  PC_BITS  program-memory address; combinational copy of `pc_in`, meaningful only while `mem_req`=1.
- `mem_req`  out  1  read request.
- `mem_ready`  in  1  memory has valid `mem_data` this cycle.
- `mem_data`  in  INSTR_BITS  fetched word.
- `ir_out`  out  INSTR_BITS  instruction register.
- `ir_valid`  out  1  `ir_out` is offered to execute.
- `exec_ready`  in  1  execute accepts `ir_out`.
- `pc_latch_data`  out  1  one-cycle PC update strobe.
- `pc_ctl`  out  2  PC next-value select: 00 = +1, 01 = `imm`, 10 = `sr1_val`, 11 = reserved (never driven).
- `imm`  out  PC_BITS  jump target, `ir[PC_BITS-1:0]`.
- `halted`  out  1  the sequencer is stopped.

## Operation
- States: IDLE, REQ, ISSUE, UPDATE, HALT. The state register is reset to IDLE.
- **IDLE:** all outputs are inactive. Next state is always REQ.
- **REQ:** `mem_req`=1.
  - If `mem_ready`=1, capture `mem_data` into `ir_out` and go to ISSUE.
  - Otherwise stay in REQ; the wait is unbounded.
- **ISSUE:** `ir_valid`=1. On `exec_ready`=1:
  - opcode HLT goes to HALT;
  - any other opcode goes to UPDATE.
  - Otherwise hold in ISSUE; `ir_out` stays stable.
- **UPDATE:** `pc_latch_data`=1 for exactly this cycle. `pc_ctl` is decoded from the opcode:
  - JMP gives 01;
  - JR gives 10;
  - any other opcode gives 00.
  - Next state is always REQ.
- **HALT:** `halted`=1; all other strobes are 0. Only `reset` exits this state.
- `imm` continuously reflects `ir_out[PC_BITS-1:0]`.
- `pc_ctl` is 00 in every state except UPDATE.
- Handshake inputs are ignored outside their own state:
  - `mem_ready` is ignored outside REQ;
  - `exec_ready` is ignored outside ISSUE.
- PC wrap-around is the PC's responsibility. The sequencer passes `pc_in` unchanged.

## Timing
- Reset values (applied asynchronously):
  - `mem_req`, `ir_valid`, `pc_latch_data`, `halted` = 0;
  - `pc_ctl` = 00;
  - `ir_out` = 0, so `imm` = 0.
- All outputs except `mem_addr` are decoded from registered state/IR only; there are no input-to-output combinational paths.
- Minimum instruction period is 3 cycles (REQ, ISSUE, UPDATE), achieved when `mem_ready` and `exec_ready` are both high on first sampling.
- The PC samples `pc_latch_data` at the end of UPDATE. `pc_in` is therefore new and stable for the whole following REQ.
- The first REQ after reset deasserts occurs 1 cycle later (the IDLE cycle).
- Reset asserted mid-REQ or mid-ISSUE: `mem_req`/`ir_valid` drop immediately. Any in-flight memory response is discarded.
- `mem_ready` and `exec_ready` asserted together: only the one belonging to the current state takes effect.

## Structure
- Shared package `fetch_pkg`:
  - opcode constants: JMP=4'hC, JR=4'hD, HLT=4'hF;
  - `pc_ctl` encodings: PC_INC, PC_IMM, PC_SR1;
  - state encoding constants.
  - The PC and decode stages import the same package.
- One sub-module, `fetch_decode`: combinational mapping from opcode to `pc_ctl` and an `is_halt` flag.

## Test plan
- Reset, release, memory always ready, exec always ready, `mem_data` = 16'h1000 (non-control opcode): `mem_req` rises 1 cycle after release; `pc_latch_data` pulses every 3rd cycle with `pc_ctl`=00; `mem_addr` follows PC 0,1,2,…, wrapping 63→0.
- `mem_ready` held low for 4 cycles in REQ: `mem_req` stays 1 and `ir_valid` stays 0; on the ready cycle IR is captured and `ir_valid` rises next cycle.
- `mem_data` = 16'hC02A, `exec_ready` delayed 3 cycles: `ir_out` held stable; then one UPDATE cycle with `pc_ctl`=01 and `imm`=6'h2A; the next `mem_addr` is 42.
- `mem_data` = 16'hD000: the UPDATE cycle drives `pc_ctl`=10; there is no `pc_latch_data` outside that cycle.
- `mem_data` = 16'hF000: after ISSUE, `halted`=1 permanently. No further `mem_req` or `pc_latch_data` occurs, even if `mem_ready`/`exec_ready` are toggled.
- Reset asserted mid-REQ, then released: outputs go to reset values the same cycle; the sequence restarts through IDLE, and `ir_out`=0 until the next capture.
